// File: rtl/interrupt_defs.sv
// Shared defaults for the interrupt controller: line count, vector layout,
// named line indices and the handler-number width.
package interrupt_defs;

  localparam int unsigned INT_LINES = 3;
  localparam logic [31:0] INT_VECTOR_BASE = 32'h0000_0100;
  localparam logic [31:0] INT_VECTOR_STRIDE = 32'h0000_0010;

  localparam int unsigned INT_LINE0 = 0;
  localparam int unsigned INT_LINE1 = 1;
  localparam int unsigned INT_LINE2 = 2;

  localparam int unsigned IRQ_NUM_W = $clog2(INT_LINES);

endpackage

// File: rtl/input_debouncer.sv
// One interrupt line: 2-flop synchroniser, optional debounce filter (built only
// when INTERRUPT_DEBOUNCE_EN is defined) and a one-cycle rising-edge pulse.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;
  logic stable;

`ifdef INTERRUPT_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] count_q;
  logic          stable_q;

  // The cycle that would bring the count to DEBOUNCE_CYCLES commits the new level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      stable_q <= 1'b0;
    end else if (sync2_q == stable_q) begin
      count_q <= '0;
    end else if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_q <= sync2_q;
      count_q  <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign stable = stable_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign stable = sync2_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= stable;
    end
  end

  assign rise = stable & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: per-line conditioning, pending latch, enable
// mask, nesting via in-service bits. Debounce enabled by INTERRUPT_DEBOUNCE_EN.
module interrupt_controller
  import interrupt_defs::*;
#(
  parameter int unsigned LINES           = INT_LINES,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] VECTOR_BASE     = INT_VECTOR_BASE,
  parameter logic [31:0] VECTOR_STRIDE   = INT_VECTOR_STRIDE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LINES-1:0]         rawInterrupt,
  input  logic                     enableWrite,
  input  logic [LINES-1:0]         enableData,
  input  logic                     irqAck,
  input  logic                     irqReturn,
  output logic                     irqRequest,
  output logic [$clog2(LINES)-1:0] irqNumber,
  output logic [31:0]              irqVector,
  output logic [LINES-1:0]         pendingOut,
  output logic [LINES-1:0]         inService
);

  localparam int unsigned NW = $clog2(LINES);

  logic [LINES-1:0] rise;
  logic [LINES-1:0] pending_q, pending_d;
  logic [LINES-1:0] enable_q, enable_d;
  logic [LINES-1:0] inservice_q, inservice_d;
  logic             req;
  logic [NW-1:0]    num;

  for (genvar g = 0; g < LINES; g++) begin : gen_line
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock(clock),
      .reset(reset),
      .raw  (rawInterrupt[g]),
      .rise (rise[g])
    );
  end

  always_comb begin
    int  cand;
    int  cur;
    logic found;
    cand  = 0;
    cur   = -1;
    found = 1'b0;
    for (int i = 0; i < int'(LINES); i++) begin
      if (pending_q[i] && enable_q[i]) begin
        cand  = i;
        found = 1'b1;
      end
      if (inservice_q[i]) cur = i;
    end
    req = found && (cand > cur);
    num = req ? NW'(cand) : '0;
  end

  always_comb begin
    logic cleared;
    cleared     = 1'b0;
    pending_d   = pending_q;
    inservice_d = inservice_q;
    enable_d    = enableWrite ? enableData : enable_q;
    if (irqReturn) begin
      for (int i = int'(LINES) - 1; i >= 0; i--) begin
        if (inservice_q[i] && !cleared) begin
          inservice_d[i] = 1'b0;
          cleared        = 1'b1;
        end
      end
    end
    if (irqAck && req) begin
      pending_d[num]   = 1'b0;
      inservice_d[num] = 1'b1;
    end
    // A fresh edge on the line being acknowledged keeps it pending.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      inservice_q <= '0;
      enable_q    <= '1;
    end else begin
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      enable_q    <= enable_d;
    end
  end

  assign irqRequest = req;
  assign irqNumber  = num;
  assign irqVector  = VECTOR_BASE + 32'(num) * VECTOR_STRIDE;
  assign pendingOut = pending_q;
  assign inService  = inservice_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Conditions the three raw interrupt buttons, latches their requests, and arbitrates them into the CPU's interrupt entry/return handshake.
- Sits directly upstream of the CPU core, between the board push-buttons and the core's interrupt logic.
- Supplies a single prioritised request with handler number and vector, and tracks nesting through in-service bits.

Parameters:
- LINES, 3: number of interrupt lines; index LINES-1 is the highest priority.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced level changes; must be ≥1.
- VECTOR_BASE, 32'h0000_0100: handler address for line 0.
- VECTOR_STRIDE, 32'h0000_0010: address distance between consecutive line handlers.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rawInterrupt  in  LINES  unsynchronised button levels, active-high
- enableWrite  in  1  one-cycle strobe; loads enableData into the mask
- enableData  in  LINES  new enable mask; 1 = line enabled
- irqAck  in  1  CPU accepted the current request; one-cycle pulse
- irqReturn  in  1  CPU executed interrupt return; one-cycle pulse
- irqRequest  out  1  request to CPU
- irqNumber  out  $clog2(LINES)  line being requested
- irqVector  out  32  handler address
- pendingOut  out  LINES  pending bits, for display/debug
- inService  out  LINES  in-service bits

Behaviour:
- Reset is asynchronous, active-high and may arrive mid-operation. It immediately clears the synchronisers, debounce counters, stable levels, pending, inService, irqRequest and irqNumber. irqVector then reads VECTOR_BASE. The enable mask resets to all ones.
- Synchronisation: each line passes through a 2-flop synchroniser.
- Debounce, per line:
  - The counter increments while the synchronised level differs from the stable level.
  - The counter clears whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the synchronised value and the counter clears.
- Edge latch: a 0→1 transition of the stable level sets pending[i] on the next edge. Latency from a clean raw rise to pendingOut is 2 + DEBOUNCE_CYCLES + 1 cycles. Falling edges have no effect.
- Masked lines:
  - A masked line still latches pending.
  - A masked line is never requested.
  - Re-enabling a masked line with pending set produces a request in the next cycle.
- Arbitration is combinational from registers:
  - The candidate is the highest index i with pending[i] & enable[i].
  - curLevel is the highest set index of inService, or -1 if inService is zero.
  - irqRequest = candidate exists AND candidate > curLevel.
  - irqNumber = candidate when irqRequest is high, else 0.
  - irqVector = VECTOR_BASE + irqNumber*VECTOR_STRIDE, computed 32-bit with wrap-around.
- Acknowledge:
  - When irqAck is high and irqRequest is high, on the next edge pending[irqNumber] clears and inService[irqNumber] sets.
  - When irqAck is high and irqRequest is low, irqAck is ignored.
- Return: irqReturn clears the highest set bit of inService. It is ignored when inService is zero.
- Simultaneous events:
  - Ack and return in the same cycle: both apply. Return clears the highest bit of the pre-cycle inService, and ack sets its bit. These bits always differ, because an ack requires candidate > curLevel.
  - A new edge on a line in the same cycle as an ack of that line: set wins, and pending stays 1.
  - enableWrite in the same cycle as an ack: the ack uses the old mask, and the new mask applies from the next cycle.
- Nesting: a higher-priority line preempts an in-service lower line. Equal or lower lines wait until the corresponding return.

Optional Feature:
- Macro INTERRUPT_DEBOUNCE_EN.
- When defined: the debounce logic operates as described above.
- When undefined: no counters are built, the stable level equals the synchroniser output, and latency to pendingOut is 3 cycles. Use this for fast simulation.
- The DEBOUNCE_CYCLES parameter is accepted in both cases.

Decomposition:
- Shared package/header interrupt_defs:
  - LINES default
  - VECTOR_BASE and VECTOR_STRIDE defaults
  - line index constants: INT_LINE0, INT_LINE1, INT_LINE2
  - the irqNumber width
- Sub-module input_debouncer: 2-flop synchroniser plus debounce counter plus rising-edge pulse output, one instance per line via generate.
- All remaining logic (pending, mask, arbitration, inService) stays in interrupt_controller.

Test Plan (all scenarios with DEBOUNCE_CYCLES=4 and INTERRUPT_DEBOUNCE_EN defined):
1. Raw line 1 rises and stays high → pendingOut=3'b010 exactly 7 cycles later; irqRequest=1, irqNumber=1, irqVector=32'h110. Then irqAck for 1 cycle → pendingOut=0, inService=3'b010, irqRequest=0.
2. A glitch of 3 high cycles on line 0 → pendingOut stays 0. A glitch of 4 high cycles on line 0 → pendingOut[0]=1.
3. Nesting: with line 0 in service, line 2 pending → irqRequest=1, irqNumber=2. Ack → inService=3'b101. irqReturn → inService=3'b001. A second irqReturn → inService=0.
4. Masking: enableWrite with enableData=3'b011, then a line 2 edge → pendingOut=3'b100 and irqRequest=0. enableWrite with 3'b111 → irqRequest=1 and irqNumber=2 the next cycle.
5. Ack and return in the same cycle: with inService=3'b001 and line 2 requested → inService=3'b100 next cycle. A new line 2 edge coincident with its ack → pending[2] remains 1.
6. Reset asserted mid-handler (inService=3'b010, pending=3'b001) → all outputs 0 immediately, irqVector=32'h100, and the mask reads all ones after reset is released.
